aemb_wbarb: RTL and testbench
=============================

Name: aemb_wbarb

Overview:
- Parametrised N-master Wishbone arbiter for AEMB unified-memory cores.
- Merges NCH master ports (instruction, data, DMA, debug, ...) onto one shared Wishbone bus.
- Adds selectable fixed or round-robin priority, registered bus outputs and a bus-timeout watchdog that returns an error to the stalled master.
- Sits between aeMB_core-class masters and the single external memory/peripheral bus.

Parameters:
- ASIZ, 32: address width.
- NCH, 2: number of master channels (>=2); channel 0 is instruction fetch by convention.
- MODE, 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin.
- TOUT, 255: cycles in BUSY without wb_ack_i before abort; 0 disables the watchdog.
- TW, 8: timeout counter width; TOUT < 2^TW.

Ports:
- sys_clk_i  in  1  clock, rising edge.
- sys_rst_i  in  1  reset, asynchronous, active-high.
- m_adr_i  in  NCH*ASIZ  per-master address; channel k occupies [k*ASIZ +: ASIZ].
- m_dat_i  in  NCH*32  per-master write data.
- m_sel_i  in  NCH*4  per-master byte selects.
- m_stb_i  in  NCH  per-master request strobe.
- m_wre_i  in  NCH  per-master write enable.
- m_dat_o  out  32  read data, broadcast to all masters; valid with m_ack_o.
- m_ack_o  out  NCH  per-master completion pulse.
- m_err_o  out  NCH  per-master timeout-error pulse.
- gnt_o  out  NCH  one-hot current grant.
- wb_adr_o  out  ASIZ  shared bus address.
- wb_dat_o  out  32  shared bus write data.
- wb_sel_o  out  4  shared bus byte selects.
- wb_stb_o  out  1  shared bus strobe.
- wb_wre_o  out  1  shared bus write enable.
- wb_dat_i  in  32  shared bus read data.
- wb_ack_i  in  1  shared bus acknowledge.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, round-robin pointer = NCH-1 (so channel 0 wins first), timeout counter 0.
- Reset asserted mid-transfer: wb_stb_o drops immediately (asynchronous); no ack or err is issued.
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If any m_stb_i is set, select a winner and, at the clock edge, register gnt_o and the winner's adr/dat/sel/wre onto the wb_* outputs.
  - Set wb_stb_o=1 and move to BUSY.
  - With no request, stay in IDLE with gnt_o=0.
- Winner selection:
  - MODE 0: lowest set index.
  - MODE 1: first set index searching upward from pointer+1, wrapping modulo NCH; the pointer updates to the winner on grant.
- BUSY:
  - wb_* outputs stay frozen. Changes on m_*_i inputs during BUSY are ignored.
  - On wb_ack_i=1: latch wb_dat_i into m_dat_o, clear wb_stb_o and wb_wre_o, set m_ack_o[g]=1, go to DONE.
  - Otherwise the timeout counter increments. If TOUT!=0 and the counter reaches TOUT-1 without an ack: clear wb_stb_o, set m_dat_o=0, set m_err_o[g]=1, go to DONE.
  - If ack arrives in the same cycle the counter expires, the ack wins.
- DONE (one cycle):
  - m_ack_o or m_err_o is high for exactly this cycle.
  - gnt_o is still valid.
  - Clear the counter, then at the next edge clear ack/err/gnt and return to IDLE.
  - Masters must drop m_stb_i on the edge where they sample ack/err; IDLE then re-arbitrates with no double issue.
- Latency:
  - Request sampled in IDLE at edge k gives wb_stb_o=1 from k+1.
  - wb_ack_i sampled at edge n gives m_ack_o from n to n+1.
  - Minimum 3 cycles per transfer; back-to-back transfers run at 1 per 3 cycles with a zero-wait-state slave.
- wb_ack_i outside BUSY is ignored.
- Fairness: in MODE 1 each continuously requesting master is granted at least once every NCH transfers.
- Invariants: at most one bit of gnt_o, m_ack_o and m_err_o is set; m_ack_o & m_err_o is always 0.

Test Plan:
- Reset, no requests -> all outputs 0, gnt_o=0 for 20 cycles; wb_ack_i pulses are ignored.
- MODE 0, NCH=2, both strobes high, zero-wait slave -> ch0 (adr 0x100) granted first. m_ack_o=01 with m_dat_o equal to slave data, then ch1 is granted only after ch0 drops its strobe.
- MODE 1, NCH=4, all four strobes held -> grant order 0,1,2,3,0 and one transfer per 3 cycles.
- Write: ch1 adr 0x2000_0004, dat 0xDEADBEEF, sel 0xF, wre=1 -> wb_* carries exactly these values, frozen until ack; 2-wait-state ack gives m_ack_o[1] 3 cycles after wb_stb_o rises.
- TOUT=16, slave never acks -> wb_stb_o drops after 16 BUSY cycles, m_err_o[g] pulses for 1 cycle with m_dat_o=0, and the next request proceeds normally.
- sys_rst_i asserted mid-BUSY, asynchronously -> wb_stb_o=0 before the next edge, no ack/err issued, and round-robin restarts at ch0.

Source files
------------

// File: rtl/aemb_wbarb.sv
// N-master Wishbone arbiter: fixed or round-robin grant, registered bus outputs,
// and a watchdog that aborts a stalled cycle and returns an error to its master.
module aemb_wbarb #(
  parameter int ASIZ = 32,
  parameter int NCH  = 2,
  parameter int MODE = 0,
  parameter int TOUT = 255,
  parameter int TW   = 8
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic [NCH*ASIZ-1:0] m_adr_i,
  input  logic [NCH*32-1:0] m_dat_i,
  input  logic [NCH*4-1:0]  m_sel_i,
  input  logic [NCH-1:0]    m_stb_i,
  input  logic [NCH-1:0]    m_wre_i,
  output logic [31:0]       m_dat_o,
  output logic [NCH-1:0]    m_ack_o,
  output logic [NCH-1:0]    m_err_o,
  output logic [NCH-1:0]    gnt_o,
  output logic [ASIZ-1:0]   wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_wre_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i
);

  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW1 = CW + 1;
  localparam logic [TW-1:0] TLIM = TW'((TOUT > 0) ? TOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   win;
  logic [TW-1:0]   cnt;

  logic [ASIZ-1:0] adr_arr [NCH];
  logic [31:0]     dat_arr [NCH];
  logic [3:0]      sel_arr [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign adr_arr[gi] = m_adr_i[gi*ASIZ +: ASIZ];
      assign dat_arr[gi] = m_dat_i[gi*32 +: 32];
      assign sel_arr[gi] = m_sel_i[gi*4 +: 4];
    end
  endgenerate

  // Round-robin searches upward from the channel after the last winner.
  always_comb begin : pick
    logic [CW:0] idx;
    logic        found;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (MODE == 0) begin
      for (int i = NCH - 1; i >= 0; i--)
        if (m_stb_i[i]) win = CW'(i);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        idx = {1'b0, rr_ptr} + CW1'(i + 1);
        if (idx >= CW1'(NCH)) idx = idx - CW1'(NCH);
        if (!found && m_stb_i[idx[CW-1:0]]) begin
          win   = idx[CW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state    <= IDLE;
      rr_ptr   <= CW'(NCH - 1);
      cnt      <= '0;
      gnt_o    <= '0;
      m_ack_o  <= '0;
      m_err_o  <= '0;
      m_dat_o  <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_stb_o <= 1'b0;
      wb_wre_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_stb_i) begin
            gnt_o    <= NCH'(1) << win;
            wb_adr_o <= adr_arr[win];
            wb_dat_o <= dat_arr[win];
            wb_sel_o <= sel_arr[win];
            wb_wre_o <= m_wre_i[win];
            wb_stb_o <= 1'b1;
            cnt      <= '0;
            state    <= BUSY;
            if (MODE != 0) rr_ptr <= win;
          end
        end
        BUSY: begin
          // An ack landing on the expiry cycle still completes normally.
          if (wb_ack_i) begin
            m_dat_o  <= wb_dat_i;
            wb_stb_o <= 1'b0;
            wb_wre_o <= 1'b0;
            m_ack_o  <= gnt_o;
            state    <= DONE;
          end else if (TOUT != 0 && cnt == TLIM) begin
            m_dat_o  <= '0;
            wb_stb_o <= 1'b0;
            wb_wre_o <= 1'b0;
            m_err_o  <= gnt_o;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          m_ack_o <= '0;
          m_err_o <= '0;
          gnt_o   <= '0;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_wbarb.sv
// Bench for aemb_wbarb: a 2-channel fixed-priority instance with a short watchdog
// and a 4-channel round-robin instance, each with its own wait-state slave.
module tb_aemb_wbarb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: NCH=2, fixed priority, TOUT=16
  logic [63:0] a_adr, a_dat;
  logic [7:0]  a_sel;
  logic [1:0]  a_stb, a_wre;
  logic [31:0] a_mdat;
  logic [1:0]  a_ack, a_err, a_gnt;
  logic [31:0] a_wbadr, a_wbdat;
  logic [3:0]  a_wbsel;
  logic        a_wbstb, a_wbwre;
  logic [31:0] a_wbdati = 32'h0;
  logic        a_wback = 1'b0;
  int          a_smode = 0, a_wait = 0, a_wc = 0;

  // Instance B: NCH=4, round-robin, TOUT=255
  logic [127:0] b_adr, b_dat;
  logic [15:0]  b_sel;
  logic [3:0]   b_stb, b_wre;
  logic [31:0]  b_mdat;
  logic [3:0]   b_ack, b_err, b_gnt;
  logic [31:0]  b_wbadr, b_wbdat;
  logic [3:0]   b_wbsel;
  logic         b_wbstb, b_wbwre;
  logic [31:0]  b_wbdati = 32'h0;
  logic         b_wback = 1'b0;
  int           b_smode = 0, b_wait = 0, b_wc = 0;
  int           b_last;

  aemb_wbarb #(.ASIZ(32), .NCH(2), .MODE(0), .TOUT(16), .TW(8)) dut_a (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .m_adr_i(a_adr), .m_dat_i(a_dat), .m_sel_i(a_sel), .m_stb_i(a_stb), .m_wre_i(a_wre),
    .m_dat_o(a_mdat), .m_ack_o(a_ack), .m_err_o(a_err), .gnt_o(a_gnt),
    .wb_adr_o(a_wbadr), .wb_dat_o(a_wbdat), .wb_sel_o(a_wbsel), .wb_stb_o(a_wbstb),
    .wb_wre_o(a_wbwre), .wb_dat_i(a_wbdati), .wb_ack_i(a_wback)
  );

  aemb_wbarb #(.ASIZ(32), .NCH(4), .MODE(1), .TOUT(255), .TW(8)) dut_b (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .m_adr_i(b_adr), .m_dat_i(b_dat), .m_sel_i(b_sel), .m_stb_i(b_stb), .m_wre_i(b_wre),
    .m_dat_o(b_mdat), .m_ack_o(b_ack), .m_err_o(b_err), .gnt_o(b_gnt),
    .wb_adr_o(b_wbadr), .wb_dat_o(b_wbdat), .wb_sel_o(b_wbsel), .wb_stb_o(b_wbstb),
    .wb_wre_o(b_wbwre), .wb_dat_i(b_wbdati), .wb_ack_i(b_wback)
  );

  // Slaves: mode 0 never acks, 1 acks after a_wait/b_wait wait states, 2 random pulses
  always @(negedge clk) begin
    if (a_smode == 2) begin
      a_wback  <= 1'($urandom_range(0, 1));
      a_wbdati <= $urandom;
    end else if (a_smode == 1 && a_wbstb === 1'b1 && a_wback === 1'b0) begin
      if (a_wc >= a_wait) begin
        a_wback <= 1'b1; a_wbdati <= $urandom; a_wc <= 0;
      end else begin
        a_wback <= 1'b0; a_wc <= a_wc + 1;
      end
    end else begin
      a_wback <= 1'b0; a_wc <= 0;
    end
  end

  always @(negedge clk) begin
    if (b_smode == 2) begin
      b_wback  <= 1'($urandom_range(0, 1));
      b_wbdati <= $urandom;
    end else if (b_smode == 1 && b_wbstb === 1'b1 && b_wback === 1'b0) begin
      if (b_wc >= b_wait) begin
        b_wback <= 1'b1; b_wbdati <= $urandom; b_wc <= 0;
      end else begin
        b_wback <= 1'b0; b_wc <= b_wc + 1;
      end
    end else begin
      b_wback <= 1'b0; b_wc <= 0;
    end
  end

  task automatic test_reset;
    rst = 1'b1; a_smode = 2; b_smode = 2;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_mdat, a_ack, a_err, a_gnt, a_wbadr, a_wbdat, a_wbsel, a_wbstb, a_wbwre,
         b_mdat, b_ack, b_err, b_gnt, b_wbadr, b_wbdat, b_wbsel, b_wbstb, b_wbwre} !== '0) begin
      errors++; $display("FAIL reset_hold: outputs not all zero a_gnt=%b b_gnt=%b a_stb=%b b_stb=%b", a_gnt, b_gnt, a_wbstb, b_wbstb);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({a_mdat, a_ack, a_err, a_gnt, a_wbstb, a_wbwre, b_mdat, b_ack, b_err, b_gnt, b_wbstb, b_wbwre} !== '0) begin
        errors++;
        $display("FAIL idle_ack_ignored cycle %0d: a ack=%b err=%b gnt=%b dat=%h b ack=%b err=%b gnt=%b dat=%h required all 0",
                 c, a_ack, a_err, a_gnt, a_mdat, b_ack, b_err, b_gnt, b_mdat);
      end
    end
    a_smode = 1; b_smode = 1; a_wait = 0; b_wait = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed;
    int t;
    a_adr = {32'h0000_0200, 32'h0000_0100};
    a_dat = {$urandom, $urandom};
    a_sel = 8'hFF; a_wre = 2'b00; a_stb = 2'b11;
    t = 0; do begin @(negedge clk); t++; end while (a_wbstb !== 1'b1 && t < 10);
    checks++;
    if ({t[3:0], a_gnt, a_wbadr, a_wbwre} !== {4'd1, 2'b01, 32'h100, 1'b0}) begin
      errors++; $display("FAIL fixed_grant0: lat=%0d gnt=%b adr=%h wre=%b required lat=1 gnt=01 adr=100 wre=0", t, a_gnt, a_wbadr, a_wbwre);
    end
    t = 0; do begin @(negedge clk); t++; end while (a_ack === 2'b00 && t < 10);
    checks++;
    if ({t[3:0], a_ack, a_err, a_gnt, a_mdat} !== {4'd1, 2'b01, 2'b00, 2'b01, a_wbdati}) begin
      errors++; $display("FAIL fixed_ack0: lat=%0d ack=%b err=%b gnt=%b dat=%h required lat=1 ack=01 err=00 gnt=01 dat=%h", t, a_ack, a_err, a_gnt, a_mdat, a_wbdati);
    end
    a_stb[0] = 1'b0;
    t = 0; do begin @(negedge clk); t++; end while (a_wbstb !== 1'b1 && t < 10);
    checks++;
    if ({t[3:0], a_gnt, a_wbadr} !== {4'd2, 2'b10, 32'h200}) begin
      errors++; $display("FAIL fixed_grant1: lat=%0d gnt=%b adr=%h required lat=2 gnt=10 adr=200", t, a_gnt, a_wbadr);
    end
    t = 0; do begin @(negedge clk); t++; end while (a_ack === 2'b00 && t < 10);
    checks++;
    if ({a_ack, a_mdat} !== {2'b10, a_wbdati}) begin
      errors++; $display("FAIL fixed_ack1: ack=%b dat=%h required ack=10 dat=%h", a_ack, a_mdat, a_wbdati);
    end
    a_stb = 2'b00;
    @(negedge clk);
    checks++;
    if ({a_ack, a_gnt} !== 4'b0) begin
      errors++; $display("FAIL fixed_done_clear: ack=%b gnt=%b required 00 00", a_ack, a_gnt);
    end
    @(negedge clk);
  endtask

  task automatic test_write;
    int t;
    logic [70:0] exp;
    exp = {32'h2000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 2'b10};
    a_wait = 2;
    a_adr = {32'h2000_0004, $urandom}; a_dat = {32'hDEAD_BEEF, $urandom};
    a_sel = 8'hF0; a_wre = 2'b10; a_stb = 2'b10;
    t = 0; do begin @(negedge clk); t++; end while (a_wbstb !== 1'b1 && t < 10);
    checks++;
    if ({a_wbadr, a_wbdat, a_wbsel, a_wbwre, a_wbstb, a_gnt} !== exp) begin
      errors++; $display("FAIL write_issue: got %h required %h", {a_wbadr, a_wbdat, a_wbsel, a_wbwre, a_wbstb, a_gnt}, exp);
    end
    // Disturb every master input while the cycle is outstanding.
    a_adr = {$urandom, $urandom}; a_dat = {$urandom, $urandom};
    a_sel = 8'h35; a_wre = 2'b01; a_stb = 2'b11;
    t = 0;
    do begin
      @(negedge clk); t++;
      if (a_ack === 2'b00) begin
        checks++;
        if ({a_wbadr, a_wbdat, a_wbsel, a_wbwre, a_wbstb, a_gnt} !== exp) begin
          errors++; $display("FAIL write_frozen t=%0d: got %h required %h", t, {a_wbadr, a_wbdat, a_wbsel, a_wbwre, a_wbstb, a_gnt}, exp);
        end
      end
    end while (a_ack === 2'b00 && t < 10);
    checks++;
    if ({t[3:0], a_ack, a_wbstb, a_wbwre, a_mdat} !== {4'd3, 2'b10, 1'b0, 1'b0, a_wbdati}) begin
      errors++; $display("FAIL write_ack: lat=%0d ack=%b stb=%b wre=%b dat=%h required lat=3 ack=10 stb=0 wre=0 dat=%h",
                         t, a_ack, a_wbstb, a_wbwre, a_mdat, a_wbdati);
    end
    a_stb = 2'b00; a_wre = 2'b00; a_wait = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int t, hi;
    a_smode = 0;
    a_adr = {$urandom, $urandom}; a_wre = 2'b00; a_stb = 2'b01;
    t = 0; do begin @(negedge clk); t++; end while (a_wbstb !== 1'b1 && t < 10);
    hi = (a_wbstb === 1'b1) ? 1 : 0;
    t = 0;
    do begin
      @(negedge clk); t++;
      if (a_wbstb === 1'b1) hi++;
    end while (a_wbstb === 1'b1 && t < 40);
    checks++;
    if (hi != 16) begin
      errors++; $display("FAIL timeout_len: stb high %0d cycles required 16", hi);
    end
    checks++;
    if ({a_err, a_ack, a_gnt, a_mdat} !== {2'b01, 2'b00, 2'b01, 32'h0}) begin
      errors++; $display("FAIL timeout_err: err=%b ack=%b gnt=%b dat=%h required err=01 ack=00 gnt=01 dat=0", a_err, a_ack, a_gnt, a_mdat);
    end
    a_stb = 2'b00;
    @(negedge clk);
    checks++;
    if ({a_err, a_gnt, a_wbstb} !== 5'b0) begin
      errors++; $display("FAIL timeout_pulse: err=%b gnt=%b stb=%b required 00 00 0", a_err, a_gnt, a_wbstb);
    end
    a_smode = 1;
    @(negedge clk);
    a_stb = 2'b10;
    t = 0; do begin @(negedge clk); t++; end while (a_ack === 2'b00 && t < 10);
    checks++;
    if ({t[3:0], a_ack, a_err, a_mdat} !== {4'd2, 2'b10, 2'b00, a_wbdati}) begin
      errors++; $display("FAIL timeout_recover: lat=%0d ack=%b err=%b dat=%h required lat=2 ack=10 err=00 dat=%h", t, a_ack, a_err, a_mdat, a_wbdati);
    end
    a_stb = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rr_order;
    logic [3:0] ackv [5];
    int at [5];
    int n, cyc;
    logic [3:0] one;
    b_wait = 0;
    b_adr = {$urandom, $urandom, $urandom, $urandom};
    b_wre = 4'h0; b_sel = 16'hFFFF; b_stb = 4'hF;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (b_ack !== 4'h0) begin ackv[n] = b_ack; at[n] = cyc; n++; end
    end
    b_stb = 4'h0;
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL rr_count: saw %0d acks required 5", n);
    end
    for (int k = 0; k < n; k++) begin
      one = 4'b0001 << (k % 4);
      checks++;
      if (ackv[k] !== one) begin
        errors++; $display("FAIL rr_order[%0d]: ack=%b required %b", k, ackv[k], one);
      end
      if (k > 0) begin
        checks++;
        if (at[k] - at[k-1] != 3) begin
          errors++; $display("FAIL rr_rate[%0d]: spacing %0d required 3", k, at[k] - at[k-1]);
        end
      end
    end
    b_last = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rr_random;
    int t, exp, c;
    logic [3:0] req, one;
    for (int it = 0; it < 30; it++) begin
      req = 4'($urandom_range(1, 15));
      b_adr = {$urandom, $urandom, $urandom, $urandom};
      b_dat = {$urandom, $urandom, $urandom, $urandom};
      b_sel = 16'($urandom); b_wre = 4'($urandom);
      b_wait = $urandom_range(0, 3);
      b_stb = req;
      exp = -1;
      for (int j = 1; j <= 4; j++) begin
        c = (b_last + j) % 4;
        if (exp < 0 && req[c]) exp = c;
      end
      one = 4'b0001 << exp;
      t = 0; do begin @(negedge clk); t++; end while (b_wbstb !== 1'b1 && t < 10);
      checks++;
      if ({t[3:0], b_gnt, b_wbadr, b_wbdat, b_wbsel, b_wbwre} !==
          {4'd1, one, b_adr[exp*32 +: 32], b_dat[exp*32 +: 32], b_sel[exp*4 +: 4], b_wre[exp]}) begin
        errors++; $display("FAIL rr_rand_grant it=%0d req=%b: lat=%0d gnt=%b adr=%h dat=%h sel=%h wre=%b required gnt=%b adr=%h",
                           it, req, t, b_gnt, b_wbadr, b_wbdat, b_wbsel, b_wbwre, one, b_adr[exp*32 +: 32]);
      end
      t = 0; do begin @(negedge clk); t++; end while (b_ack === 4'h0 && t < 10);
      checks++;
      if ({t[3:0], b_ack, b_err, b_mdat} !== {4'(b_wait + 1), one, 4'h0, b_wbdati}) begin
        errors++; $display("FAIL rr_rand_ack it=%0d: lat=%0d ack=%b err=%b dat=%h required lat=%0d ack=%b dat=%h",
                           it, t, b_ack, b_err, b_mdat, b_wait + 1, one, b_wbdati);
      end
      b_last = exp;
      b_stb = 4'h0;
      @(negedge clk);
    end
    b_wait = 0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int t;
    b_smode = 0;
    b_stb = 4'b0100; b_wre = 4'b0100;
    t = 0; do begin @(negedge clk); t++; end while (b_wbstb !== 1'b1 && t < 10);
    repeat (2) @(negedge clk);
    checks++;
    if ({b_gnt, b_wbstb} !== {4'b0100, 1'b1}) begin
      errors++; $display("FAIL arst_pre: gnt=%b stb=%b required 0100 1", b_gnt, b_wbstb);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({b_wbstb, b_wbwre, b_gnt, b_ack, b_err} !== 14'b0) begin
      errors++; $display("FAIL arst_immediate: stb=%b wre=%b gnt=%b ack=%b err=%b required all 0", b_wbstb, b_wbwre, b_gnt, b_ack, b_err);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; b_stb = 4'h0; b_wre = 4'h0; b_smode = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({b_ack, b_err, b_wbstb} !== 9'b0) begin
        errors++; $display("FAIL arst_quiet cycle %0d: ack=%b err=%b stb=%b required 0", c, b_ack, b_err, b_wbstb);
      end
    end
    b_stb = 4'hF;
    t = 0; do begin @(negedge clk); t++; end while (b_wbstb !== 1'b1 && t < 10);
    checks++;
    if (b_gnt !== 4'b0001) begin
      errors++; $display("FAIL arst_rr_restart: gnt=%b required 0001", b_gnt);
    end
    t = 0; do begin @(negedge clk); t++; end while (b_ack === 4'h0 && t < 10);
    checks++;
    if ({b_ack, b_mdat} !== {4'b0001, b_wbdati}) begin
      errors++; $display("FAIL arst_after_ack: ack=%b dat=%h required 0001 %h", b_ack, b_mdat, b_wbdati);
    end
    b_stb = 4'h0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_adr = '0; a_dat = '0; a_sel = '0; a_stb = '0; a_wre = '0;
    b_adr = '0; b_dat = '0; b_sel = '0; b_stb = '0; b_wre = '0;
    b_last = 3;
    test_reset;
    test_fixed;
    test_write;
    test_timeout;
    test_rr_order;
    test_rr_random;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
